// File: rtl/memory_bank.sv
// memory_bank: simple-dual-port block-RAM bank with byte-lane writes,
// write-first forwarding on read/write address collision, a registered
// read path with a one-cycle valid strobe, and an optional post-reset
// clear sweep.
//
// Build option:
//   MEM_CLEAR_EN  defined   -> IDLE/CLEAR sweep FSM compiled in; the array
//                              is zeroed after every reset and on clear_i.
//                 undefined -> no FSM, busy_o tied low, clear_i ignored,
//                              array contents undefined at power-up.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset (control registers only)
//   wr_i     write enable, active low
//   waddr_i  write address
//   data_i   write data
//   be_i     per-lane write enables, active high
//   rd_i     read enable, active low
//   raddr_i  read address
//   clear_i  start a clear sweep (sampled in IDLE only)
//   data_o   registered read data
//   valid_o  one-cycle strobe, data_o updated this cycle
//   busy_o   clear sweep in progress, accesses ignored

module memory_bank #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_i,
  input  logic [ADDR_WIDTH-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_i,
  input  logic                             rd_i,
  input  logic [ADDR_WIDTH-1:0]            raddr_i,
  input  logic                             clear_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             valid_o,
  output logic                             busy_o
);

  localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Storage array; deliberately never reset
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sweep write request (tied off when the clear feature is absent)
  logic                  sweep_c;
  logic [ADDR_WIDTH-1:0] sweep_addr_c;
  logic                  busy_int;

`ifdef MEM_CLEAR_EN

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q;

  // State, sweep counter and busy flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // Next-state logic; the counter parks on the last word instead of wrapping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sweep_c      = (state_q == ST_CLEAR);
  assign sweep_addr_c = cnt_q;
  assign busy_int     = busy_q;

`else

  logic unused_clear;

  assign unused_clear = clear_i;
  assign sweep_c      = 1'b0;
  assign sweep_addr_c = '0;
  assign busy_int     = 1'b0;

`endif

  assign busy_o = busy_int;

  // Accepted user accesses
  logic wr_acc_c;
  logic rd_acc_c;

  assign wr_acc_c = ~wr_i & ~busy_int;
  assign rd_acc_c = ~rd_i & ~busy_int;

  // Single array write port shared by the sweep and user writes
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [LANES-1:0]      wr_be_c;

  always_comb begin
    wr_en_c   = wr_acc_c;
    wr_addr_c = waddr_i;
    wr_data_c = data_i;
    wr_be_c   = be_i;
    if (sweep_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = sweep_addr_c;
      wr_data_c = '0;
      wr_be_c   = '1;
    end
  end

  // Byte-lane array write
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_be_c[k]) begin
          mem[wr_addr_c][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_c[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read word with write-first forwarding of the lanes written this cycle
  logic [DATA_WIDTH-1:0] rd_word_c;

  always_comb begin
    rd_word_c = mem[raddr_i];
    if (wr_acc_c && (waddr_i == raddr_i)) begin
      for (int k = 0; k < LANES; k++) begin
        if (be_i[k]) begin
          rd_word_c[k*BYTE_WIDTH +: BYTE_WIDTH] = data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered read data and valid strobe; data holds between reads
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc_c;
      if (rd_acc_c) begin
        data_q <= rd_word_c;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_memory_bank.sv
module tb_memory_bank;

  localparam int DEPTH = 64;
`ifdef MEM_CLEAR_EN
  localparam logic CLEAR_ON  = 1'b1;
  localparam int   SWEEP_LEN = 64;
`else
  localparam logic CLEAR_ON  = 1'b0;
  localparam int   SWEEP_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr, rd, clear;
  logic [5:0]  waddr, raddr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        valid, busy;

  int checks   = 0;
  int failures = 0;
  int prints   = 0;

  always #5 clk = ~clk;

  memory_bank #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (wr),
    .waddr_i (waddr),
    .data_i  (din),
    .be_i    (be),
    .rd_i    (rd),
    .raddr_i (raddr),
    .clear_i (clear),
    .data_o  (dout),
    .valid_o (valid),
    .busy_o  (busy)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];
  logic        m_busy   = CLEAR_ON;
  logic        m_valid  = 1'b0;
  logic [31:0] m_data   = 32'h0;
  logic [3:0]  m_dknown = 4'hF;
  int          m_sweep  = 0;

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  initial begin
    logic [31:0] w;
    logic [3:0]  kn;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 4'h0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy   = CLEAR_ON;
        m_sweep  = 0;
        m_valid  = 1'b0;
        m_data   = 32'h0;
        m_dknown = 4'hF;
      end else if (m_busy) begin
        m_mem[m_sweep]   = 32'h0;
        m_known[m_sweep] = 4'hF;
        m_sweep          = m_sweep + 1;
        if (m_sweep == DEPTH) m_busy = 1'b0;
        m_valid = 1'b0;
      end else begin
        m_valid = !rd;
        if (!rd) begin
          w  = m_mem[raddr];
          kn = m_known[raddr];
          if (!wr && waddr == raddr) begin
            w  = (w & ~lane_mask(be)) | (din & lane_mask(be));
            kn = kn | be;
          end
          m_data   = w;
          m_dknown = kn;
        end
        if (!wr) begin
          m_mem[waddr]   = (m_mem[waddr] & ~lane_mask(be)) | (din & lane_mask(be));
          m_known[waddr] = m_known[waddr] | be;
        end
        if (CLEAR_ON && clear) begin
          m_busy  = 1'b1;
          m_sweep = 0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Per-cycle comparison against the model, just after each falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check32("cyc_busy", 32'(busy), 32'(m_busy));
      check32("cyc_valid", 32'(valid), 32'(m_valid));
      check32("cyc_data", dout & lane_mask(m_dknown), m_data & lane_mask(m_dknown));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wr = 1'b1; rd = 1'b1; clear = 1'b0; be = 4'h0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = 1'b0; waddr = a; din = d; be = b;
    step();
    idle_in();
  endtask

  task automatic do_read(input logic [5:0] a);
    rd = 1'b0; raddr = a;
    step();
    idle_in();
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; waddr = '0; raddr = '0; din = '0;
    idle_in();
    repeat (3) step();
    check32("rst_busy", 32'(busy), 32'(CLEAR_ON));
    check32("rst_valid", 32'(valid), 32'h0);
    check32("rst_data", dout, 32'h0);

    // Sweep length after reset release
    rst = 1'b0;
    wait_busy(n);
    check32("sweep_len_reset", 32'(n), 32'(SWEEP_LEN));

    // First non-busy read of the top word
    do_read(6'd63);
    check32("rd63_valid", 32'(valid), 32'h1);
`ifdef MEM_CLEAR_EN
    check32("rd63_data", dout, 32'h0);
`endif
    step();
    check32("rd63_valid_drop", 32'(valid), 32'h0);

    // Full then partial write
    do_write(6'd5, 32'hDEADBEEF, 4'b1111);
    do_write(6'd5, 32'h11223344, 4'b0101);
    do_read(6'd5);
    check32("partial_wr", dout, 32'hDE22BE44);

    // be=0 write is a no-op
    do_write(6'd5, 32'h0, 4'b0000);
    do_read(6'd5);
    check32("be0_noop", dout, 32'hDE22BE44);

    // Collision: write-first forwarding of enabled lanes
    do_write(6'd9, 32'hAAAAAAAA, 4'b1111);
    wr = 1'b0; waddr = 6'd9; din = 32'h12345678; be = 4'b0011;
    rd = 1'b0; raddr = 6'd9;
    step();
    idle_in();
    check32("collide_data", dout, 32'hAAAA5678);
    check32("collide_valid", 32'(valid), 32'h1);
    do_read(6'd9);
    check32("collide_reread", dout, 32'hAAAA5678);

    // Back-to-back reads, then data holds with valid low
    rd = 1'b0; raddr = 6'd5;
    step();
    check32("b2b_first", dout, 32'hDE22BE44);
    raddr = 6'd9;
    step();
    check32("b2b_second", dout, 32'hAAAA5678);
    check32("b2b_valid", 32'(valid), 32'h1);
    idle_in();
    step();
    check32("hold_valid", 32'(valid), 32'h0);
    check32("hold_data", dout, 32'hAAAA5678);

    // Write then read on the next cycle
    do_write(6'd12, 32'h01020304, 4'b1111);
    do_read(6'd12);
    check32("wr_then_rd", dout, 32'h01020304);

    // Accesses during a clear sweep are dropped
    do_write(6'd7, 32'hCAFEF00D, 4'b1111);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check32("clear_busy", 32'(busy), 32'(CLEAR_ON));
    n = 0;
    while (busy && n < 200) begin
      if (n == 10) begin
        wr = 1'b0; waddr = 6'd3; din = 32'hFFFFFFFF; be = 4'hF;
      end else if (n == 11) begin
        rd = 1'b0; raddr = 6'd7;
      end else begin
        idle_in();
      end
      if (n == 13) check32("busy_no_valid", 32'(valid), 32'h0);
      n++;
      step();
    end
    idle_in();
    check32("sweep_len_clear", 32'(n), 32'(SWEEP_LEN));
    do_read(6'd3);
`ifdef MEM_CLEAR_EN
    check32("busy_wr_dropped", dout, 32'h0);
`endif
    do_read(6'd7);
`ifdef MEM_CLEAR_EN
    check32("swept_word", dout, 32'h0);
`else
    check32("no_clear_keeps", dout, 32'hCAFEF00D);
`endif

    // Reset in the middle of a sweep
    do_write(6'd7, 32'hCAFEF00D, 4'b1111);
    do_read(6'd7);
    check32("pre_rst_data", dout, 32'hCAFEF00D);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    check32("midrst_busy", 32'(busy), 32'(CLEAR_ON));
    check32("midrst_valid", 32'(valid), 32'h0);
    check32("midrst_data", dout, 32'h0);
    repeat (3) step();
    rst = 1'b0;
    wait_busy(n);
    check32("sweep_len_rerun", 32'(n), 32'(SWEEP_LEN));

    // First accepted cycle after the sweep (or after reset without one)
    do_write(6'd0, 32'h0BADF00D, 4'b1111);
    do_read(6'd0);
    check32("first_wr_rd", dout, 32'h0BADF00D);
    do_read(6'd20);
`ifdef MEM_CLEAR_EN
    check32("rerun_cleared", dout, 32'h0);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
